// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] MEM_BYTES_DEF = 32'd1024;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   // Instruction word plus the byte address it was fetched from.
   typedef struct packed {
      logic [WORD_W-1:0] ins;
      logic [WORD_W-1:0] pc;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: MEMI address/data, redirect input and valid/ready output stream.
interface fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic              en;
   logic [WORD_W-1:0] DR;
   logic [WORD_W-1:0] INS;
   logic              br_valid;
   logic [WORD_W-1:0] br_target;
   logic              ins_valid;
   logic              ins_ready;
   logic [WORD_W-1:0] ins_out;
   logic [WORD_W-1:0] pc_out;
   logic [WORD_W-1:0] ins_count;
   logic              fault;

   modport master (
      input  en, INS, br_valid, br_target, ins_ready,
      output DR, ins_valid, ins_out, pc_out, ins_count, fault
   );

   modport slave (
      output en, INS, br_valid, br_target, ins_ready,
      input  DR, ins_valid, ins_out, pc_out, ins_count, fault
   );

endinterface

// File: rtl/fetch_ctrl.sv
// Sequential instruction fetch with redirect, downstream backpressure and a sticky
// fault on bad redirect targets. MEMI sits beside this block, read combinationally via DR/INS.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = 32'd0,
   parameter logic [WORD_W-1:0] MEM_BYTES = MEM_BYTES_DEF
) (
   input logic            clk,
   input logic            rst,
   fetch_ctrl_if.master   bus
);

   state_t            state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   fetch_pkt_t        pkt_q, pkt_d;
   logic              valid_q, valid_d;
   logic [WORD_W-1:0] count_q, count_d;
   logic              fault_q, fault_d;

   logic              xfer;
   logic              out_free;
   logic              br_ok;
   logic              br_bad;
   logic [WORD_W-1:0] pc_next;

   assign xfer     = valid_q && bus.ins_ready;
   assign out_free = !valid_q || bus.ins_ready;
   assign br_ok    = bus.br_valid && (bus.br_target[1:0] == 2'b00) && (bus.br_target < MEM_BYTES);
   assign br_bad   = bus.br_valid && !br_ok;
   assign pc_next  = (pc_q == MEM_BYTES - WORD_W'(4)) ? '0 : pc_q + WORD_W'(4);

   // Next-state and datapath update; a completed transfer frees the output register.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pkt_d   = pkt_q;
      valid_d = xfer ? 1'b0 : valid_q;
      count_d = count_q + WORD_W'(xfer);
      fault_d = fault_q;

      case (state_q)
         ST_IDLE: begin
            if (br_bad) begin
               fault_d = 1'b1;
               valid_d = 1'b0;
               state_d = ST_FAULT;
            end else begin
               if (br_ok) begin
                  pc_d    = bus.br_target;
                  valid_d = 1'b0;
               end
               if (bus.en) state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (br_bad) begin
               fault_d = 1'b1;
               valid_d = 1'b0;
               state_d = ST_FAULT;
            end else begin
               if (br_ok) begin
                  pc_d    = bus.br_target;
                  valid_d = 1'b0;
               end else if (out_free) begin
                  pkt_d   = '{ins: bus.INS, pc: pc_q};
                  valid_d = 1'b1;
                  pc_d    = pc_next;
               end
               if (!bus.en) state_d = ST_IDLE;
            end
         end

         ST_FAULT: begin
            valid_d = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         pkt_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pkt_q   <= pkt_d;
         valid_q <= valid_d;
         count_q <= count_d;
         fault_q <= fault_d;
      end
   end

   assign bus.DR        = pc_q;
   assign bus.ins_valid = valid_q;
   assign bus.ins_out   = pkt_q.ins;
   assign bus.pc_out    = pkt_q.pc;
   assign bus.ins_count = count_q;
   assign bus.fault     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational MEMI model and a transfer scoreboard.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   fetch_pkt_t exp_q[$];

   fetch_ctrl_if bus ();

   fetch_ctrl #(.RESET_PC(32'd0), .MEM_BYTES(32'd1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // MEMI image; unlisted words carry their own address so mis-fetches are visible.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'd0:   return 32'h20080005;
         32'd4:   return 32'h20090003;
         32'd8:   return 32'h01095020;
         32'd12:  return 32'hAC0A0000;
         default: return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   assign bus.INS = mem_word(bus.DR);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] a);
      exp_q.push_back('{ins: mem_word(a), pc: a});
   endtask

   // Scores the transfer due at the coming edge, then returns mid-cycle after it.
   task automatic cyc();
      fetch_pkt_t p;
      if (!rst && bus.ins_valid && bus.ins_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_unexpected: observed pc %h expected no transfer", bus.pc_out);
         end else begin
            p = exp_q.pop_front();
            chk("sb_pc", bus.pc_out, p.pc);
            chk("sb_ins", bus.ins_out, p.ins);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.en = 1'b0;
      bus.br_valid = 1'b0;
      bus.br_target = '0;
      bus.ins_ready = 1'b0;
      cyc();
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, 32'(bus.ins_valid), 32'd0);
      chk({tag, "_ins"},   bus.ins_out,        32'd0);
      chk({tag, "_pc"},    bus.pc_out,         32'd0);
      chk({tag, "_count"}, bus.ins_count,      32'd0);
      chk({tag, "_fault"}, 32'(bus.fault),     32'd0);
      chk({tag, "_dr"},    bus.DR,             32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.en = 1'b0;
      bus.br_valid = 1'b0;
      bus.br_target = '0;
      bus.ins_ready = 1'b0;

      // Scenario 1: straight-line fetch
      do_reset();
      chk_reset("rst0");
      bus.en = 1'b1;
      bus.ins_ready = 1'b1;
      push_exp(32'd0); push_exp(32'd4); push_exp(32'd8); push_exp(32'd12);
      cyc();
      chk("s1_idle_valid", 32'(bus.ins_valid), 32'd0);
      cyc();
      chk("s1_pc0", bus.pc_out, 32'd0);
      chk("s1_ins0", bus.ins_out, 32'h20080005);
      cyc();
      chk("s1_pc4", bus.pc_out, 32'd4);
      cyc();
      chk("s1_pc8", bus.pc_out, 32'd8);
      cyc();
      chk("s1_pc12", bus.pc_out, 32'd12);
      chk("s1_ins12", bus.ins_out, 32'hAC0A0000);
      cyc();
      chk("s1_count", bus.ins_count, 32'd4);

      // Scenario 2: backpressure while pc_out=4
      do_reset();
      bus.en = 1'b1;
      bus.ins_ready = 1'b1;
      push_exp(32'd0); push_exp(32'd4); push_exp(32'd8);
      cyc();
      cyc();
      cyc();
      chk("s2_pc4", bus.pc_out, 32'd4);
      bus.ins_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("s2_hold_ins", bus.ins_out, 32'h20090003);
         chk("s2_hold_pc", bus.pc_out, 32'd4);
         chk("s2_hold_dr", bus.DR, 32'd8);
         chk("s2_hold_valid", 32'(bus.ins_valid), 32'd1);
      end
      bus.ins_ready = 1'b1;
      cyc();
      chk("s2_release_pc", bus.pc_out, 32'd8);
      chk("s2_count", bus.ins_count, 32'd2);

      // Scenario 3: legal redirect in RUN, same cycle as a transfer
      bus.br_valid = 1'b1;
      bus.br_target = 32'd100;
      cyc();
      chk("s3_squash", 32'(bus.ins_valid), 32'd0);
      chk("s3_dr", bus.DR, 32'd100);
      chk("s3_count", bus.ins_count, 32'd3);
      bus.br_valid = 1'b0;
      push_exp(32'd100);
      cyc();
      chk("s3_pc100", bus.pc_out, 32'd100);
      chk("s3_valid", 32'(bus.ins_valid), 32'd1);

      // Scenario 4: misaligned redirect faults and is sticky
      bus.br_valid = 1'b1;
      bus.br_target = 32'd6;
      cyc();
      chk("s4_fault", 32'(bus.fault), 32'd1);
      chk("s4_valid", 32'(bus.ins_valid), 32'd0);
      chk("s4_dr", bus.DR, 32'd104);
      chk("s4_count", bus.ins_count, 32'd4);
      bus.br_target = 32'd200;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("s4_sticky_fault", 32'(bus.fault), 32'd1);
         chk("s4_sticky_valid", 32'(bus.ins_valid), 32'd0);
         chk("s4_sticky_dr", bus.DR, 32'd104);
      end
      do_reset();
      chk_reset("s4_rst");

      // Scenario 5: wrap at the top of MEMI
      bus.en = 1'b1;
      bus.ins_ready = 1'b1;
      bus.br_valid = 1'b1;
      bus.br_target = 32'd1020;
      cyc();
      chk("s5_dr", bus.DR, 32'd1020);
      chk("s5_valid", 32'(bus.ins_valid), 32'd0);
      bus.br_valid = 1'b0;
      push_exp(32'd1020); push_exp(32'd0);
      cyc();
      chk("s5_pc1020", bus.pc_out, 32'd1020);
      chk("s5_wrap_dr", bus.DR, 32'd0);
      cyc();
      chk("s5_pc0", bus.pc_out, 32'd0);
      chk("s5_ins0", bus.ins_out, 32'h20080005);

      // Scenario 6: reset mid-RUN with a valid output
      chk("s6_pre_valid", 32'(bus.ins_valid), 32'd1);
      do_reset();
      chk_reset("s6_rst");

      // Out-of-range redirect (== MEM_BYTES) faults
      bus.en = 1'b1;
      bus.br_valid = 1'b1;
      bus.br_target = 32'd1024;
      cyc();
      chk("s7_fault", 32'(bus.fault), 32'd1);
      chk("s7_dr", bus.DR, 32'd0);

      // Pending output drains in IDLE without new capture; en=0 with redirect
      do_reset();
      bus.en = 1'b1;
      push_exp(32'd0);
      cyc();
      cyc();
      bus.en = 1'b0;
      cyc();
      cyc();
      chk("s8_idle_valid", 32'(bus.ins_valid), 32'd1);
      chk("s8_idle_pc", bus.pc_out, 32'd0);
      chk("s8_idle_dr", bus.DR, 32'd4);
      bus.ins_ready = 1'b1;
      cyc();
      chk("s8_drain_valid", 32'(bus.ins_valid), 32'd0);
      chk("s8_drain_count", bus.ins_count, 32'd1);
      chk("s8_drain_dr", bus.DR, 32'd4);
      bus.en = 1'b1;
      cyc();
      bus.en = 1'b0;
      bus.br_valid = 1'b1;
      bus.br_target = 32'd40;
      cyc();
      chk("s8_br_dr", bus.DR, 32'd40);
      chk("s8_br_valid", 32'(bus.ins_valid), 32'd0);
      bus.br_valid = 1'b0;
      cyc();
      chk("s8_stopped_valid", 32'(bus.ins_valid), 32'd0);
      chk("s8_stopped_dr", bus.DR, 32'd40);
      chk("s8_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
